// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcode sequencer generating the CPU control word and ctrlen
//
// Purpose: holds the instruction register and the microstep counter. Each step's
// control word comes from a 34-bit microcode ROM addressed by {flags, ir, step}.
// ROM bit 32 (LOAD_IR) captures main_bus into ir, and ROM bit 33 (LAST) restarts
// the step counter at 0.
// The ROM is a fixed internal image (cw = {op, 8'h5A, flags, step}; LOAD_IR at
// step 1; LAST at step op[2:0], or step 2 when op[2:0] is 0; never LAST when
// op[7] is set).
// Optional macro SEQ_HALT_OPCODE_EN: an IR load of 8'hFF halts the sequencer until reset.
//
// Ports:
//   clk          in   sequencer clock (CPU iclk phase)
//   rst          in   asynchronous active-low reset
//   main_bus     in   8-bit CPU main bus, sampled on LOAD_IR steps
//   flags        in   FLAG_W CPU flags, used live in the ROM address
//   hold         in   freezes sequencing while high (sampled at posedge)
//   control_word out  32-bit control word, NOP_WORD outside RUN
//   ctrlen       out  control enable, low only in RESET
//   step         out  current microstep
//   ir           out  current opcode
module control_sequencer #(
    parameter int          STEP_W   = 3,
    parameter int          FLAG_W   = 4,
    parameter string       ROM_FILE = "microcode.hex",
    parameter logic [31:0] NOP_WORD = 32'h3BF83FCF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        main_bus,
    input  logic [FLAG_W-1:0] flags,
    input  logic              hold,
    output logic [31:0]       control_word,
    output logic              ctrlen,
    output logic [STEP_W-1:0] step,
    output logic [7:0]        ir
);

    localparam int ADDR_W = FLAG_W + 8 + STEP_W;

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_RUN    = 2'd1,
        S_HOLD   = 2'd2
`ifdef SEQ_HALT_OPCODE_EN
        ,
        S_HALTED = 2'd3
`endif
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [STEP_W-1:0] step_next;
    logic [7:0]        ir_next;

    logic [ADDR_W-1:0] rom_addr;
    logic [33:0]       rom_entry;
    logic              load_ir;
    logic              last_step;

    // flags are live: a flag change re-addresses the ROM without a clock edge
    assign rom_addr  = {flags, ir, step};
    assign load_ir   = rom_entry[32];
    assign last_step = rom_entry[33];

    function automatic logic [33:0] builtin_entry(input logic [ADDR_W-1:0] a);
        logic [FLAG_W-1:0] f;
        logic [7:0]        op;
        logic [STEP_W-1:0] s;
        logic [STEP_W-1:0] last_at;
        {f, op, s} = a;
        last_at = (op[2:0] == 3'd0) ? STEP_W'(2) : STEP_W'(op[2:0]);
        return {(!op[7] && (s == last_at)), (s == STEP_W'(1)),
                op, 8'h5A, 8'(f), 8'(s)};
    endfunction

    always_comb rom_entry = builtin_entry(rom_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RESET;
            step  <= '0;
            ir    <= 8'h00;
        end else begin
            state <= state_next;
            step  <= step_next;
            ir    <= ir_next;
        end
    end

    always_comb begin
        state_next = state;
        step_next  = step;
        ir_next    = ir;
        case (state)
            S_RESET: state_next = S_RUN;
            S_RUN: begin
                // entering HOLD does not consume the current step
                if (hold) begin
                    state_next = S_HOLD;
                end else begin
                    step_next = last_step ? '0 : step + STEP_W'(1);
                    if (load_ir) begin
                        ir_next = main_bus;
`ifdef SEQ_HALT_OPCODE_EN
                        if (main_bus == 8'hFF) begin
                            state_next = S_HALTED;
                            step_next  = '0;
                        end
`endif
                    end
                end
            end
            S_HOLD: begin
                if (!hold) state_next = S_RUN;
            end
            default: begin
                // HALTED: frozen until reset
            end
        endcase
    end

    always_comb begin
        control_word = NOP_WORD;
        ctrlen       = 1'b1;
        case (state)
            S_RUN:   control_word = rom_entry[31:0];
            S_RESET: ctrlen = 1'b0;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer (builtin ROM image)
module tb_control_sequencer;

    localparam logic [31:0] NOP = 32'h3BF83FCF;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        hold     = 1'b0;
    logic [7:0]  main_bus = 8'h00;
    logic [3:0]  flags    = 4'h0;
    logic [31:0] control_word;
    logic        ctrlen;
    logic [2:0]  step;
    logic [7:0]  ir;

    control_sequencer #(
        .STEP_W   (3),
        .FLAG_W   (4),
        .ROM_FILE ("builtin"),
        .NOP_WORD (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .main_bus     (main_bus),
        .flags        (flags),
        .hold         (hold),
        .control_word (control_word),
        .ctrlen       (ctrlen),
        .step         (step),
        .ir           (ir)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: plain integers and flags describing the sequencer's situation
    bit m_reset  = 1'b1;
    bit m_held   = 1'b0;
    bit m_halted = 1'b0;
    int m_step   = 0;
    int m_ir     = 0;

    function automatic logic [31:0] rom_cw(int f, int op, int s);
        return (op << 24) | 32'h005A0000 | (f << 8) | s;
    endfunction

    function automatic bit rom_load(int s);
        return s == 1;
    endfunction

    function automatic bit rom_last(int op, int s);
        int last_at;
        last_at = (op % 8 == 0) ? 2 : op % 8;
        return (op < 128) && (s == last_at);
    endfunction

    function automatic void model_reset();
        m_reset  = 1'b1;
        m_held   = 1'b0;
        m_halted = 1'b0;
        m_step   = 0;
        m_ir     = 0;
    endfunction

    function automatic void model_edge();
        bit ld;
        bit lst;
        if (!rst) begin
            model_reset();
        end else if (m_reset) begin
            m_reset = 1'b0;
        end else if (m_halted) begin
            // stays halted
        end else if (m_held) begin
            if (!hold) m_held = 1'b0;
        end else if (hold) begin
            m_held = 1'b1;
        end else begin
            ld  = rom_load(m_step);
            lst = rom_last(m_ir, m_step);
            if (ld) m_ir = int'(main_bus);
            m_step = lst ? 0 : (m_step + 1) % 8;
`ifdef SEQ_HALT_OPCODE_EN
            if (ld && main_bus == 8'hFF) begin
                m_halted = 1'b1;
                m_step   = 0;
            end
`endif
        end
    endfunction

    function automatic logic [31:0] model_cw();
        if (m_reset || m_held || m_halted) return NOP;
        return rom_cw(int'(flags), m_ir, m_step);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_model(input string name);
        chk({name, " cw"}, control_word, model_cw());
        chk({name, " ctrlen"}, 32'(ctrlen), 32'(!m_reset));
        chk({name, " step"}, 32'(step), 32'(m_step));
        chk({name, " ir"}, 32'(ir), 32'(m_ir));
    endtask

    task automatic tick();
        model_edge();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  bus;
        logic [2:0]  exp_step;
        logic [7:0]  exp_ir;
        logic [31:0] exp_cw;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic [7:0] b, logic [2:0] s, logic [7:0] i, logic [31:0] c);
        vec_t v;
        v.bus = b; v.exp_step = s; v.exp_ir = i; v.exp_cw = c;
        vecs.push_back(v);
    endfunction

    initial begin
        // expected state after each edge, starting from the first edge after reset release
        add(8'h00, 3'd0, 8'h00, 32'h005A0000);
        add(8'h00, 3'd1, 8'h00, 32'h005A0001);
        add(8'h12, 3'd2, 8'h12, 32'h125A0002);
        add(8'h00, 3'd0, 8'h12, 32'h125A0000);
        add(8'h00, 3'd1, 8'h12, 32'h125A0001);
        add(8'h04, 3'd2, 8'h04, 32'h045A0002);
        add(8'h00, 3'd3, 8'h04, 32'h045A0003);
        add(8'h00, 3'd4, 8'h04, 32'h045A0004);
        add(8'h00, 3'd0, 8'h04, 32'h045A0000);
        add(8'h00, 3'd1, 8'h04, 32'h045A0001);
        add(8'h80, 3'd2, 8'h80, 32'h805A0002);
        for (int s = 3; s < 8; s++) add(8'h00, 3'(s), 8'h80, 32'h805A0000 | s);
        add(8'h00, 3'd0, 8'h80, 32'h805A0000);
        add(8'h00, 3'd1, 8'h80, 32'h805A0001);
        add(8'h01, 3'd2, 8'h01, 32'h015A0002);
        for (int s = 3; s < 8; s++) add(8'h00, 3'(s), 8'h01, 32'h015A0000 | s);
        add(8'h00, 3'd0, 8'h01, 32'h015A0000);
        add(8'h00, 3'd1, 8'h01, 32'h015A0001);
        add(8'h33, 3'd0, 8'h33, 32'h335A0000);
        add(8'h00, 3'd1, 8'h33, 32'h335A0001);

        // reset with the clock idle takes effect immediately
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("reset cw", control_word, NOP);
        chk("reset ctrlen", 32'(ctrlen), 32'd0);
        chk("reset step", 32'(step), 32'd0);
        chk("reset ir", 32'(ir), 32'd0);
        rst = 1'b1;
        #1;
        chk("released no edge ctrlen", 32'(ctrlen), 32'd0);

        foreach (vecs[k]) begin
            main_bus = vecs[k].bus;
            tick();
            chk($sformatf("vec%0d step", k), 32'(step), 32'(vecs[k].exp_step));
            chk($sformatf("vec%0d ir", k), 32'(ir), 32'(vecs[k].exp_ir));
            chk($sformatf("vec%0d cw", k), control_word, vecs[k].exp_cw);
            chk($sformatf("vec%0d ctrlen", k), 32'(ctrlen), 32'd1);
        end

        // hold at step 2 for three edges
        main_bus = 8'h06;
        tick();
        chk("pre-hold cw", control_word, 32'h065A0002);
        hold = 1'b1;
        #1;
        chk("hold not sampled yet", control_word, 32'h065A0002);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hold%0d cw", c), control_word, NOP);
            chk($sformatf("hold%0d step", c), 32'(step), 32'd2);
            chk($sformatf("hold%0d ctrlen", c), 32'(ctrlen), 32'd1);
        end
        hold = 1'b0;
        tick();
        chk("resume cw", control_word, 32'h065A0002);
        tick();
        chk("after resume cw", control_word, 32'h065A0003);

        // live flags change without a clock edge
        #1 flags = 4'b0010;
        #1;
        chk("flags live cw", control_word, 32'h065A0203);

        // reset mid-instruction aborts and restarts at opcode 0 step 0
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid reset cw", control_word, NOP);
        chk("mid reset step", 32'(step), 32'd0);
        chk("mid reset ir", 32'(ir), 32'd0);
        rst = 1'b1;
        tick();
        chk("restart cw", control_word, 32'h005A0200);
        chk("restart ctrlen", 32'(ctrlen), 32'd1);

        // randomized run against the reference model
        for (int i = 0; i < 600; i++) begin
            main_bus = 8'($urandom);
            hold     = ($urandom_range(0, 4) == 0);
            flags    = 4'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0;
                model_reset();
                #1;
                check_model("rand reset");
                rst = 1'b1;
            end
            tick();
            check_model("rand");
            #1 flags = 4'($urandom);
            #1 chk("rand flags live cw", control_word, model_cw());
        end
        hold = 1'b0;

`ifdef SEQ_HALT_OPCODE_EN
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        main_bus = 8'h00;
        tick();
        tick();
        main_bus = 8'hFF;
        tick();
        chk("halt ir", 32'(ir), 32'hFF);
        chk("halt step", 32'(step), 32'd0);
        chk("halt cw", control_word, NOP);
        chk("halt ctrlen", 32'(ctrlen), 32'd1);
        for (int c = 0; c < 10; c++) begin
            hold     = 1'($urandom);
            main_bus = 8'($urandom);
            tick();
            chk($sformatf("halted%0d cw", c), control_word, NOP);
            chk($sformatf("halted%0d ctrlen", c), 32'(ctrlen), 32'd1);
            chk($sformatf("halted%0d ir", c), 32'(ir), 32'hFF);
            chk($sformatf("halted%0d step", c), 32'(step), 32'd0);
        end
        hold = 1'b0;
        rst  = 1'b0;
        model_reset();
        #1;
        check_model("halt exit reset");
        rst = 1'b1;
        tick();
        check_model("halt exit run");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
